// File: rtl/uart_tx_buf.sv
// uart_tx_buf
//   UART transmitter with a one-entry holding register (double buffering).
//   Each frame is a start bit, DBIT data bits sent LSB first, an optional parity
//   bit and a stop period of SB_TICK oversampling ticks. Bit timing comes from
//   the shared 16x s_tick, so one bit period is 16 ticks. While a frame is
//   shifting, the host can load the next byte into the holding register, and
//   that byte follows the current stop period with no idle cycle in between.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous reset, active low (0 = in reset)
//   s_tick       in   one-clk oversampling tick, 16 per bit period
//   tx_start     in   write strobe; din is taken when tx_start=1 and tx_ready=1
//   din[7:0]     in   byte to transmit (din[7] is ignored when DBIT=7)
//   tx_ready     out  holding register empty
//   busy         out  transmitter FSM is not idle
//   tx_done_tick out  one-clk pulse on the last tick of a frame's stop period
//   tx           out  registered serial line, idles high
module uart_tx_buf #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done_tick,
    output logic       tx
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic [4:0] BIT_LAST  = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

    state_t            state_q, state_d;
    logic [4:0]        s_q, s_d;          // tick count within the current bit
    logic [2:0]        n_q, n_d;          // data bit index
    logic [DBIT-1:0]   b_q, b_d;          // data shift register, LSB on the line
    logic              p_q, p_d;          // running parity, seeded with PARITY_ODD
    logic              tx_q, tx_d;
    logic [DBIT-1:0]   hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic              load;              // move the held byte into the shifter

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        p_d          = p_q;
        tx_d         = tx_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        load         = 1'b0;
        tx_done_tick = 1'b0;

        // Host write. A strobe while the holding register is full is dropped,
        // including the cycle in which the held byte is being consumed.
        if (tx_start && !hold_valid_q) begin
            hold_d       = din[DBIT-1:0];
            hold_valid_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (hold_valid_q) begin
                    load = 1'b1;
                end
            end

            ST_START: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        state_d = ST_DATA;
                        s_d     = '0;
                        n_d     = '0;
                        tx_d    = b_q[0];
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        p_d = p_q ^ b_q[0];
                        b_d = b_q >> 1;
                        s_d = '0;
                        if (n_q == N_LAST) begin
                            if (PARITY_EN) begin
                                state_d = ST_PARITY;
                                tx_d    = p_q ^ b_q[0];
                            end else begin
                                state_d = ST_STOP;
                                tx_d    = 1'b1;
                            end
                        end else begin
                            n_d  = n_q + 3'd1;
                            tx_d = b_q[1];
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

            ST_PARITY: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        state_d = ST_STOP;
                        s_d     = '0;
                        tx_d    = 1'b1;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

            ST_STOP: begin
                if (s_tick) begin
                    if (s_q == STOP_LAST) begin
                        tx_done_tick = 1'b1;
                        s_d          = '0;
                        // A waiting byte starts its frame straight from here,
                        // so back-to-back frames have no idle cycle.
                        if (hold_valid_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Frame start, shared by idle and end-of-stop. Never coincides with a
        // host write because a write needs the holding register empty.
        if (load) begin
            state_d      = ST_START;
            b_d          = hold_q;
            hold_valid_d = 1'b0;
            s_d          = '0;
            p_d          = PARITY_ODD;
            tx_d         = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            s_q          <= '0;
            n_q          <= '0;
            b_q          <= '0;
            p_q          <= 1'b0;
            tx_q         <= 1'b1;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed in the same cycle, independent of statement order.
            state_q      <= state_d;
            s_q          <= s_d;
            n_q          <= n_d;
            b_q          <= b_d;
            p_q          <= p_d;
            tx_q         <= tx_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign tx_ready = ~hold_valid_q;
    assign busy     = (state_q != ST_IDLE);
    assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf
//   Drives four uart_tx_buf instances (8N1, 8E1, 8O1, 7N2) from one clock and
//   one shared tick generator; only one instance is exercised at a time. A
//   monitor logs the selected tx line once per s_tick, and the expected line is
//   built from the frame rules (start, data LSB first, parity from a bit count,
//   stop ticks) for every byte the bench sends.
`timescale 1ns/1ps
module tb_uart_tx_buf;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       s_tick = 1'b0;
    logic [7:0] din    = 8'h00;
    logic [3:0] tx_start_v = 4'h0;
    logic [3:0] tx_ready_v, busy_v, done_v, tx_v;

    int dbit_c [4] = '{8, 8, 8, 7};
    int pen_c  [4] = '{0, 1, 1, 0};
    int podd_c [4] = '{0, 0, 1, 0};
    int sbt_c  [4] = '{16, 16, 16, 32};

    int tests_run    = 0;
    int tests_failed = 0;

    // tick generator controls
    int tick_per = 4;
    bit tick_en  = 1'b1;
    int tick_div = 0;

    // monitor state (written only by the monitor process)
    int         sel = 0;
    logic       line_q[$];
    int         len_q[$];
    int         done_cnt  = 0;
    int         frame_cnt = 0;

    // per-test baselines and expected bytes
    int         base_line = 0;
    int         base_len  = 0;
    int         base_done = 0;
    logic [7:0] sent_q[$];

    always #5 clk = ~clk;

    uart_tx_buf #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_8n1 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start_v[0]), .din(din),
        .tx_ready(tx_ready_v[0]), .busy(busy_v[0]), .tx_done_tick(done_v[0]), .tx(tx_v[0]));
    uart_tx_buf #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_8e1 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start_v[1]), .din(din),
        .tx_ready(tx_ready_v[1]), .busy(busy_v[1]), .tx_done_tick(done_v[1]), .tx(tx_v[1]));
    uart_tx_buf #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_8o1 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start_v[2]), .din(din),
        .tx_ready(tx_ready_v[2]), .busy(busy_v[2]), .tx_done_tick(done_v[2]), .tx(tx_v[2]));
    uart_tx_buf #(.DBIT(7), .SB_TICK(32), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_7n2 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start_v[3]), .din(din),
        .tx_ready(tx_ready_v[3]), .busy(busy_v[3]), .tx_done_tick(done_v[3]), .tx(tx_v[3]));

    // one-clk s_tick every tick_per cycles while enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tick_en) begin
                if (tick_div >= tick_per - 1) begin
                    tick_div = 0;
                    s_tick   = 1'b1;
                end else begin
                    tick_div = tick_div + 1;
                    s_tick   = 1'b0;
                end
            end else begin
                s_tick = 1'b0;
            end
        end
    end

    // line monitor: one sample per tick, tick count per frame, done pulses
    always @(negedge clk) begin
        if (!reset) begin
            frame_cnt = 0;
        end else begin
            if (s_tick) line_q.push_back(tx_v[sel]);
            if (s_tick && busy_v[sel]) frame_cnt = frame_cnt + 1;
            if (done_v[sel]) begin
                done_cnt = done_cnt + 1;
                len_q.push_back(frame_cnt);
                frame_cnt = 0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic mark();
        base_line = line_q.size();
        base_len  = len_q.size();
        base_done = done_cnt;
        sent_q.delete();
    endtask

    task automatic send(input int inst, input logic [7:0] d);
        @(posedge clk);
        #1;
        din              = d;
        tx_start_v[inst] = 1'b1;
        @(posedge clk);
        #1;
        tx_start_v[inst] = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int c = 0;
        while ((done_cnt - base_done) < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        tests_run++;
        if ((done_cnt - base_done) < n) begin
            tests_failed++;
            $display("FAIL %s wait_done: got %0d done pulses, required %0d within %0d clk",
                     name, done_cnt - base_done, n, budget);
        end
    endtask

    // Expected line from the frame rules, compared segment by segment.
    task automatic check_line(input int inst, input string name);
        int idx = base_line;
        int bad;
        foreach (sent_q[f]) begin
            logic       lev[$];
            int         tl[$];
            logic [7:0] d;
            logic [7:0] mask;
            d    = sent_q[f];
            mask = (dbit_c[inst] == 7) ? 8'h7F : 8'hFF;
            lev.push_back(1'b0); tl.push_back(16);
            for (int i = 0; i < dbit_c[inst]; i++) begin
                lev.push_back(d[i]); tl.push_back(16);
            end
            if (pen_c[inst] != 0) begin
                lev.push_back((($countones(d & mask) + podd_c[inst]) % 2) == 1);
                tl.push_back(16);
            end
            lev.push_back(1'b1); tl.push_back(sbt_c[inst]);
            while (idx < line_q.size() && line_q[idx] === 1'b1) idx++;
            for (int sg = 0; sg < lev.size(); sg++) begin
                bad = 0;
                for (int k = 0; k < tl[sg]; k++) begin
                    if (idx >= line_q.size() || line_q[idx] !== lev[sg]) bad++;
                    idx++;
                end
                tests_run++;
                if (bad != 0) begin
                    tests_failed++;
                    $display("FAIL %s frame %0d (0x%02h) segment %0d: %0d of %0d tick samples differ from required level %b",
                             name, f, d, sg, bad, tl[sg], lev[sg]);
                end
            end
        end
        bad = 0;
        while (idx < line_q.size()) begin
            if (line_q[idx] !== 1'b1) bad++;
            idx++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL %s trailing idle: %0d low tick samples after last frame, required 0", name, bad);
        end
    endtask

    task automatic check_lens(input int inst, input string name, input int n);
        int exp_len = 16 * (1 + dbit_c[inst] + pen_c[inst]) + sbt_c[inst];
        tests_run++;
        if (len_q.size() - base_len != n) begin
            tests_failed++;
            $display("FAIL %s frame count: got %0d, required %0d", name, len_q.size() - base_len, n);
        end
        for (int i = base_len; i < len_q.size(); i++) begin
            tests_run++;
            if (len_q[i] != exp_len) begin
                tests_failed++;
                $display("FAIL %s frame length: got %0d ticks, required %0d", name, len_q[i], exp_len);
            end
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({tx_v, busy_v, tx_ready_v, done_v} !== 16'hF0F0) begin
            tests_failed++;
            $display("FAIL reset_values: tx/busy/ready/done = %h, required f0f0",
                     {tx_v, busy_v, tx_ready_v, done_v});
        end
        @(posedge clk);
        #3 reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        tests_run++;
        if ({tx_v, busy_v, tx_ready_v, done_v} !== 16'hF0F0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: tx/busy/ready/done = %h, required f0f0",
                     {tx_v, busy_v, tx_ready_v, done_v});
        end
    endtask

    // One frame with start latency and end-of-frame busy checks.
    task automatic test_single_frame(input int inst, input string name, input logic [7:0] d);
        sel      = inst;
        tick_per = 4;
        @(posedge clk);
        #1;
        mark();
        sent_q.push_back(d);
        send(inst, d);
        tests_run++;
        if ({tx_ready_v[inst], tx_v[inst]} !== 2'b01) begin
            tests_failed++;
            $display("FAIL %s accept_edge: ready,tx = %b, required 01", name, {tx_ready_v[inst], tx_v[inst]});
        end
        @(posedge clk);
        #1;
        tests_run++;
        if ({tx_v[inst], busy_v[inst], tx_ready_v[inst]} !== 3'b011) begin
            tests_failed++;
            $display("FAIL %s start_latency: tx,busy,ready = %b, required 011",
                     name, {tx_v[inst], busy_v[inst], tx_ready_v[inst]});
        end
        wait_done(1, 3000, name);
        tests_run++;
        if (busy_v[inst] !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s busy_after_done: got %b, required 0", name, busy_v[inst]);
        end
        check_line(inst, name);
        check_lens(inst, name, 1);
    endtask

    task automatic test_random_frames(input int inst, input string name, input int nframes);
        logic [7:0] d;
        sel      = inst;
        tick_per = $urandom_range(1, 4);
        @(posedge clk);
        #1;
        mark();
        for (int f = 0; f < nframes; f++) begin
            d = 8'($urandom);
            sent_q.push_back(d);
            send(inst, d);
            wait_done(f + 1, 3000, name);
            repeat ($urandom_range(0, 20)) @(posedge clk);
        end
        #1;
        check_line(inst, name);
        check_lens(inst, name, nframes);
    endtask

    task automatic test_back_to_back();
        int gaps = 0;
        int c    = 0;
        sel      = 0;
        tick_per = 2;
        @(posedge clk);
        #1;
        mark();
        sent_q.push_back(8'h55);
        sent_q.push_back(8'h0F);
        din           = 8'h55;
        tx_start_v[0] = 1'b1;
        @(posedge clk);          // accepts 0x55
        #1;
        din = 8'hFF;             // still strobing while the held byte is consumed
        @(posedge clk);
        #1;
        tx_start_v[0] = 1'b0;
        tests_run++;
        if ({tx_ready_v[0], tx_v[0]} !== 2'b10) begin
            tests_failed++;
            $display("FAIL b2b consume_edge_drop: ready,tx = %b, required 10", {tx_ready_v[0], tx_v[0]});
        end
        repeat (10) @(posedge clk);
        send(0, 8'h0F);
        tests_run++;
        if (tx_ready_v[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b held: ready = %b, required 0", tx_ready_v[0]);
        end
        send(0, 8'hFF);
        tests_run++;
        if (tx_ready_v[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b full_write: ready = %b, required 0", tx_ready_v[0]);
        end
        while ((done_cnt - base_done) < 2 && c < 3000) begin
            @(posedge clk);
            #1;
            if ((done_cnt - base_done) < 2 && busy_v[0] !== 1'b1) gaps++;
            c++;
        end
        tests_run++;
        if ((done_cnt - base_done) < 2) begin
            tests_failed++;
            $display("FAIL b2b wait_done: got %0d done pulses, required 2", done_cnt - base_done);
        end
        tests_run++;
        if (gaps != 0) begin
            tests_failed++;
            $display("FAIL b2b idle_gap: busy low for %0d clk between frames, required 0", gaps);
        end
        repeat (300) @(posedge clk);
        #1;
        tests_run++;
        if ((done_cnt - base_done) != 2 || busy_v[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b final: done pulses %0d busy %b, required 2 and 0", done_cnt - base_done, busy_v[0]);
        end
        check_line(0, "b2b");
        check_lens(0, "b2b", 2);
    endtask

    task automatic test_reset_mid_frame();
        int c = 0;
        int done_ref;
        int bad = 0;
        sel      = 0;
        tick_per = 4;
        @(posedge clk);
        #1;
        mark();
        send(0, 8'h96);
        @(posedge clk);
        #1;
        send(0, 8'hC3);
        tests_run++;
        if (tx_ready_v[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid held: ready = %b, required 0", tx_ready_v[0]);
        end
        while (frame_cnt < 70 && c < 2000) begin
            @(posedge clk);
            c++;
        end
        #2;
        done_ref = done_cnt;
        reset    = 1'b0;
        #1;
        tests_run++;
        if ({tx_v[0], busy_v[0], tx_ready_v[0], done_v[0]} !== 4'b1010) begin
            tests_failed++;
            $display("FAIL rst_mid async: tx,busy,ready,done = %b, required 1010",
                     {tx_v[0], busy_v[0], tx_ready_v[0], done_v[0]});
        end
        repeat (20) begin
            @(posedge clk);
            #1;
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0 || done_cnt != done_ref) begin
            tests_failed++;
            $display("FAIL rst_mid during: %0d bad cycles, %0d done pulses, required 0 and 0",
                     bad, done_cnt - done_ref);
        end
        @(posedge clk);
        #3 reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        tests_run++;
        if ({busy_v[0], tx_ready_v[0], tx_v[0]} !== 3'b011) begin
            tests_failed++;
            $display("FAIL rst_mid held_dropped: busy,ready,tx = %b, required 011",
                     {busy_v[0], tx_ready_v[0], tx_v[0]});
        end
        mark();
        sent_q.push_back(8'h3C);
        send(0, 8'h3C);
        wait_done(1, 3000, "rst_mid_3c");
        check_line(0, "rst_mid_3c");
        check_lens(0, "rst_mid_3c", 1);
    endtask

    task automatic test_stall();
        int         c = 0;
        int         changes = 0;
        int         cnt_ref;
        logic       tx_ref;
        logic [7:0] d;
        sel      = 0;
        tick_per = 3;
        @(posedge clk);
        #1;
        mark();
        d = 8'($urandom);
        sent_q.push_back(d);
        send(0, d);
        while (frame_cnt < 40 && c < 2000) begin
            @(posedge clk);
            c++;
        end
        #2;
        tick_en = 1'b0;
        @(posedge clk);
        #2;
        tx_ref  = tx_v[0];
        cnt_ref = frame_cnt;
        repeat (100) begin
            @(posedge clk);
            #2;
            if (tx_v[0] !== tx_ref || busy_v[0] !== 1'b1) changes++;
        end
        tests_run++;
        if (changes != 0) begin
            tests_failed++;
            $display("FAIL stall line: %0d cycles with tx/busy changed, required 0", changes);
        end
        tests_run++;
        if (frame_cnt != cnt_ref) begin
            tests_failed++;
            $display("FAIL stall ticks: frame tick count %0d, required %0d", frame_cnt, cnt_ref);
        end
        tick_en = 1'b1;
        wait_done(1, 3000, "stall");
        check_line(0, "stall");
        check_lens(0, "stall", 1);
    endtask

    initial begin
        test_reset();
        test_single_frame(0, "8n1_a5", 8'hA5);
        test_single_frame(1, "8e1_07", 8'h07);
        test_single_frame(2, "8o1_07", 8'h07);
        test_single_frame(3, "7n2_ff", 8'hFF);
        test_back_to_back();
        test_reset_mid_frame();
        test_stall();
        test_random_frames(0, "rand_8n1", 5);
        test_random_frames(1, "rand_8e1", 3);
        test_random_frames(2, "rand_8o1", 3);
        test_random_frames(3, "rand_7n2", 3);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
